// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM encoding, bus widths and the access-check helper.
package data_mem_responder_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Misaligned, or word index beyond the stored words.
  function automatic logic addr_err(
    input logic [31:0] addr,
    input int unsigned depth
  );
    return (addr[1:0] != 2'b00) ||
           ({2'b00, addr[31:2]} >= 32'(depth));
  endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// Word-organised data RAM: byte-masked synchronous write,
// combinational read. Contents are not reset.
module data_mem_responder_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [BE_W-1:0]   i_be,
  input  logic [AW-1:0]     i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be[b]) begin
          r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory target: req/ack handshake with programmable
// wait states, error response and byte-masked stores.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic              ack_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic              r_ack;
  logic              r_err;
  logic [WORD_W-1:0] r_rdata;

  logic              w_idle;
  logic [31:0]       w_addr;
  logic              w_we;
  logic              w_err;
  logic              w_wr;
  logic [WORD_W-1:0] w_rd_mem;
  logic [WORD_W-1:0] w_rdata_nxt;

  // With zero wait states RESP is entered on the capture edge,
  // so the check and read must look at the live request.
  assign w_idle = (r_state == S_IDLE);
  assign w_addr = w_idle ? addr_i : r_addr;
  assign w_we   = w_idle ? we_i : r_we;
  assign w_err  = addr_err(w_addr, DEPTH);
  assign w_wr   = (r_state == S_RESP) && r_we && !r_err;

  assign w_rdata_nxt = w_err ? '0 :
                       (w_we ? r_rdata : w_rd_mem);

  data_mem_responder_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_wr),
    .i_be    (r_be),
    .i_waddr (r_addr[AW+1:2]),
    .i_wdata (r_wdata),
    .i_raddr (w_addr[AW+1:2]),
    .o_rdata (w_rd_mem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_we    <= we_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_be    <= be_i;
            if (WAIT_STATES > 0) begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_INIT;
            end else begin
              r_state <= S_RESP;
              r_ack   <= 1'b1;
              r_err   <= w_err;
              r_rdata <= w_rdata_nxt;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
            r_ack   <= 1'b1;
            r_err   <= w_err;
            r_rdata <= w_rdata_nxt;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign ack_o   = r_ack;
  assign err_o   = r_err;
  assign rdata_o = r_rdata;
  assign busy_o  = !w_idle;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two
// wait states, one with none for back-to-back traffic.
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;

  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        ack, err, busy;
  logic [31:0] rdata;

  logic        req0, we0;
  logic [31:0] addr0, wdata0;
  logic [3:0]  be0;
  logic        ack0, err0, busy0;
  logic [31:0] rdata0;

  int nerr;
  int nchk;

  data_mem_responder #(.DEPTH(256), .WAIT_STATES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .be_i    (be),
    .ack_o   (ack),
    .rdata_o (rdata),
    .err_o   (err),
    .busy_o  (busy)
  );

  data_mem_responder #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req0),
    .we_i    (we0),
    .addr_i  (addr0),
    .wdata_i (wdata0),
    .be_i    (be0),
    .ack_o   (ack0),
    .rdata_o (rdata0),
    .err_o   (err0),
    .busy_o  (busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on the two-wait-state instance.
  task automatic txn(input string tag,
                     input logic we_v,
                     input logic [31:0] a,
                     input logic [31:0] wd,
                     input logic [3:0] b,
                     input logic exp_err,
                     input logic [31:0] exp_rd,
                     input logic rst_at_ack);
    req = 1'b1; we = we_v; addr = a; wdata = wd; be = b;
    tick();
    chk({tag, " busy1"}, 32'(busy), 32'd1);
    chk({tag, " ack1"}, 32'(ack), 32'd0);
    tick();
    chk({tag, " ack2"}, 32'(ack), 32'd0);
    tick();
    chk({tag, " ack3"}, 32'(ack), 32'd1);
    chk({tag, " err"}, 32'(err), 32'(exp_err));
    chk({tag, " rdata"}, rdata, exp_rd);
    req = 1'b0;
    we = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0;
    if (rst_at_ack) begin
      rst_n = 1'b0;
      #1;
      chk({tag, " rst ack"}, 32'(ack), 32'd0);
      chk({tag, " rst err"}, 32'(err), 32'd0);
      chk({tag, " rst rdata"}, rdata, 32'd0);
      chk({tag, " rst busy"}, 32'(busy), 32'd0);
      tick();
      rst_n = 1'b1;
    end else begin
      tick();
      chk({tag, " ack drop"}, 32'(ack), 32'd0);
      chk({tag, " err drop"}, 32'(err), 32'd0);
      chk({tag, " idle"}, 32'(busy), 32'd0);
    end
  endtask

  logic        t5_we   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] t5_addr [5] = '{32'h20, 32'h24, 32'h20, 32'h24, 32'h20};
  logic [31:0] t5_wd   [5] = '{32'h01020304, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0};
  logic [31:0] t5_rd   [5] = '{32'h0, 32'h0, 32'h01020304, 32'hA5A5A5A5, 32'h01020304};

  initial begin
    nerr = 0;
    nchk = 0;
    rst_n = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0;
    tick();
    tick();
    chk("reset ack", 32'(ack), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset busy0", 32'(busy0), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle no req", 32'(busy), 32'd0);

    txn("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0);
    txn("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0);
    txn("st10m", 1'b1, 32'h10, 32'h11223344, 4'h5, 1'b0, 32'hDEADBEEF, 1'b0);
    txn("ld10m", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDE22BE44, 1'b0);
    txn("ld13", 1'b0, 32'h13, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0);
    txn("ld400", 1'b0, 32'h400, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0);
    txn("st0", 1'b1, 32'h0, 32'h0A0B0C0D, 4'hF, 1'b0, 32'h0, 1'b0);
    txn("st400", 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0, 1'b0);
    txn("st11", 1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0, 1'b0);
    txn("ld0", 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0A0B0C0D, 1'b0);
    txn("ld10k", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDE22BE44, 1'b0);
    txn("st3fc", 1'b1, 32'h3FC, 32'h55AA55AA, 4'hF, 1'b0, 32'hDE22BE44, 1'b0);
    txn("ld3fc", 1'b0, 32'h3FC, 32'h0, 4'h0, 1'b0, 32'h55AA55AA, 1'b0);
    txn("st4be0", 1'b1, 32'h4, 32'h12345678, 4'h0, 1'b0, 32'h55AA55AA, 1'b0);

    txn("rstld", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDE22BE44, 1'b1);
    tick();
    txn("rsterr", 1'b0, 32'h13, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1);
    tick();

    req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'hCAFEF00D; be = 4'hF;
    tick();
    chk("abort busy", 32'(busy), 32'd1);
    req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort busy rst", 32'(busy), 32'd0);
    chk("abort ack rst", 32'(ack), 32'd0);
    tick();
    chk("abort no ack1", 32'(ack), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("abort no ack2", 32'(ack), 32'd0);
    tick();
    chk("abort no ack3", 32'(ack), 32'd0);
    txn("ld10a", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDE22BE44, 1'b0);

    req0 = 1'b1; we0 = t5_we[0]; addr0 = t5_addr[0];
    wdata0 = t5_wd[0]; be0 = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("b2b ack %0d", i), 32'(ack0), 32'd1);
      chk($sformatf("b2b busy %0d", i), 32'(busy0), 32'd1);
      chk($sformatf("b2b err %0d", i), 32'(err0), 32'd0);
      chk($sformatf("b2b rdata %0d", i), rdata0, t5_rd[i]);
      if (i < 4) begin
        we0 = t5_we[i+1]; addr0 = t5_addr[i+1]; wdata0 = t5_wd[i+1];
      end else begin
        req0 = 1'b0;
      end
      tick();
      chk($sformatf("b2b gap ack %0d", i), 32'(ack0), 32'd0);
      chk($sformatf("b2b gap busy %0d", i), 32'(busy0), 32'd0);
    end
    tick();
    chk("b2b stays idle", 32'(busy0), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
